instr_mem_loadable: RTL and testbench
=====================================

// Module: instr_mem_loadable
// PURPOSE
//  Parametrised, loadable instruction memory for the single-cycle RISC-V core.
//  On reset it clears every word to NOP (ADDI x0,x0,0 = 0x00000013) with an init sequencer.
//  A host load port then writes the program one 32-bit word per cycle.
//  The core fetch port returns a registered word with alignment and range checks.
// PARAMETERS
//  DEPTH_WORDS  32           number of 32-bit words; power of 2, >=4 (default = 128 bytes)
//  AW           $clog2(DEPTH_WORDS)  word-index width (derived localparam, not overridable)
//  NOP_WORD     32'h00000013 fill value at init, and data returned on a faulted fetch
// PORTS
//  clk              in   1   rising-edge clock
//  reset            in   1   synchronous, active-high reset
//  init_done        out  1   1 = memory cleared, block in RUN
//  ld_valid         in   1   host load request
//  ld_ready         out  1   load accepted this cycle when ld_valid&ld_ready
//  ld_addr          in   AW  word index to write
//  ld_data          in   32  instruction word, {b3,b2,b1,b0}, little-endian in memory
//  fetch_req        in   1   core fetch request
//  pc               in   32  byte address of fetch
//  fetch_valid      out  1   instruction_code/fetch_err valid (1 cycle after req)
//  instruction_code out  32  fetched word
//  fetch_err        out  2   00 ok, 01 misaligned (pc[1:0]!=0), 10 out of range, 11 both
// BEHAVIOUR
//  Storage: DEPTH_WORDS x 32 bit array, word index = pc[AW+1:2]; byte order little-endian.
//  FSM states: INIT, RUN.
//   reset=1 (any state, any cycle) -> INIT, init_ptr=0.
//    All outputs 0: init_done, ld_ready, fetch_valid, instruction_code, fetch_err.
//   INIT: each cycle mem[init_ptr]<=NOP_WORD, init_ptr++.
//    After the write at init_ptr==DEPTH_WORDS-1, go to RUN on the next edge.
//    INIT lasts exactly DEPTH_WORDS cycles after reset deasserts.
//    In INIT: ld_ready=0, fetch_req ignored, fetch_valid=0.
//   RUN: init_done=1, ld_ready=1 every cycle; never returns to INIT except by reset.
//  Load: in RUN, ld_valid=1 -> mem[ld_addr]<=ld_data at that edge.
//   ld_addr wraps naturally; it is AW bits, so no range error exists on this port.
//  Fetch: in RUN, fetch_req sampled at edge N -> at edge N+1:
//   fetch_valid=1
//   fetch_err={range,misalign}, range = (pc>>2)>=DEPTH_WORDS, misalign = pc[1:0]!=0
//   instruction_code = mem[pc[AW+1:2]] if fetch_err==0, else NOP_WORD
//  fetch_req=0 -> fetch_valid=0 next cycle; instruction_code/fetch_err hold the last values.
//  Back-to-back fetches: one result per cycle, no bubbles.
//  Simultaneous load and fetch, same word: the fetch returns the OLD contents
//   (read-before-write); the new word is visible to fetches issued from the next cycle.
//  Simultaneous load and fetch, different words: both complete independently.
//  Reset during INIT restarts the clear from word 0.
//  Reset during RUN clears all contents again, and drops the fetch issued in the reset cycle.
//  No combinational path from any input to any output; all outputs are registered.
// TESTING
//  1. reset 1 cycle, then idle -> init_done=0 for 32 cycles, 1 on cycle 33;
//     fetch pc=0x7C -> 0x00000013, err=00.
//  2. After init: load addr0=0x002081B3, addr1=0x4020A1B3; fetch pc=0 then pc=4 back-to-back
//     -> 0x002081B3 then 0x4020A1B3 on consecutive cycles, fetch_valid high for both.
//  3. Same-cycle load addr2=0x000202CC and fetch pc=8 -> 0x00000013;
//     refetch pc=8 -> 0x000202CC.
//  4. Fetch pc=0x06 -> err=01, code=NOP;
//     pc=0x80 -> err=10; pc=0x81 -> err=11; ok fetch after each -> err=00.
//  5. fetch_req pulsed once then low 3 cycles -> fetch_valid 1 for one cycle;
//     instruction_code holds its value.
//  6. reset at init_ptr=10, and reset mid-RUN after loading addr0 ->
//     fresh 32-cycle INIT each time; fetch pc=0 -> 0x00000013.

Source files
------------

// File: rtl/instr_mem_loadable.sv
// Loadable instruction memory: reset-triggered NOP clear, host word-load port and
// registered core fetch port with alignment/range fault reporting.
module instr_mem_loadable #(
    parameter int          DEPTH_WORDS = 32,
    parameter logic [31:0] NOP_WORD    = 32'h0000_0013,
    localparam int         AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          reset,
    output logic          init_done,
    input  logic          ld_valid,
    output logic          ld_ready,
    input  logic [AW-1:0] ld_addr,
    input  logic [31:0]   ld_data,
    input  logic          fetch_req,
    input  logic [31:0]   pc,
    output logic          fetch_valid,
    output logic [31:0]   instruction_code,
    output logic [1:0]    fetch_err
);

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t        state;
    state_t        state_nx;
    logic [AW-1:0] init_ptr;
    logic [31:0]   mem [DEPTH_WORDS];

    // {range, misalign}: range fault when the word index falls past the array
    function automatic logic [1:0] fetch_fault(input logic [31:0] addr);
        fetch_fault = {(addr >> 2) >= 32'(DEPTH_WORDS), addr[1:0] != 2'b00};
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_INIT;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        if (state == S_INIT && init_ptr == AW'(DEPTH_WORDS - 1)) begin
            state_nx = S_RUN;
        end
    end

    always_comb begin
        init_done = 1'b0;
        ld_ready  = 1'b0;
        if (state == S_RUN) begin
            init_done = 1'b1;
            ld_ready  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            init_ptr <= '0;
        end else if (state == S_INIT) begin
            init_ptr <= init_ptr + 1'b1;
        end
    end

    // Single write port: the clear sequencer owns it in INIT, the host in RUN
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state == S_INIT) begin
                mem[init_ptr] <= NOP_WORD;
            end else if (ld_valid) begin
                mem[ld_addr] <= ld_data;
            end
        end
    end

    // ---- stage p0: fetch request decode ----
    logic          accept_p0;
    logic [1:0]    fault_p0;
    logic [AW-1:0] idx_p0;

    assign accept_p0 = (state == S_RUN) && fetch_req;
    assign fault_p0  = fetch_fault(pc);
    assign idx_p0    = pc[AW+1:2];

    // ---- stage p1: registered fetch result (reads old data on a same-word load) ----
    logic        vld_p1;
    logic [31:0] code_p1;
    logic [1:0]  err_p1;

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p1  <= 1'b0;
            code_p1 <= '0;
            err_p1  <= '0;
        end else begin
            vld_p1 <= accept_p0;
            if (accept_p0) begin
                err_p1  <= fault_p0;
                code_p1 <= (fault_p0 == 2'b00) ? mem[idx_p0] : NOP_WORD;
            end
        end
    end

    assign fetch_valid      = vld_p1;
    assign instruction_code = code_p1;
    assign fetch_err        = err_p1;

endmodule

// File: tb/tb_instr_mem_loadable.sv
// Scoreboard bench for instr_mem_loadable: fetch expectations are queued when
// issued and retired against fetch_valid on the falling edge.
module tb_instr_mem_loadable;

    localparam int          DEPTH = 32;
    localparam int          AW    = $clog2(DEPTH);
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic          clk = 1'b0;
    logic          reset;
    logic          init_done;
    logic          ld_valid;
    logic          ld_ready;
    logic [AW-1:0] ld_addr;
    logic [31:0]   ld_data;
    logic          fetch_req;
    logic [31:0]   pc;
    logic          fetch_valid;
    logic [31:0]   instruction_code;
    logic [1:0]    fetch_err;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] exp_code_q[$];
    logic [1:0]  exp_err_q[$];

    instr_mem_loadable #(.DEPTH_WORDS(DEPTH), .NOP_WORD(NOP)) dut (
        .clk              (clk),
        .reset            (reset),
        .init_done        (init_done),
        .ld_valid         (ld_valid),
        .ld_ready         (ld_ready),
        .ld_addr          (ld_addr),
        .ld_data          (ld_data),
        .fetch_req        (fetch_req),
        .pc               (pc),
        .fetch_valid      (fetch_valid),
        .instruction_code (instruction_code),
        .fetch_err        (fetch_err)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        logic [31:0] c;
        logic [1:0]  e;
        if (fetch_valid === 1'b1) begin
            if (exp_code_q.size() == 0) begin
                check_val("unexpected_fetch_valid", 32'd1, 32'd0);
            end else begin
                c = exp_code_q.pop_front();
                e = exp_err_q.pop_front();
                check_val("fetch_code", instruction_code, c);
                check_val("fetch_err", {30'b0, fetch_err}, {30'b0, e});
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_init(output int n);
        n = 0;
        while (init_done !== 1'b1 && n < 200) begin
            cyc();
            n++;
        end
    endtask

    task automatic do_fetch(input logic [31:0] a, input logic [31:0] c, input logic [1:0] e);
        fetch_req = 1'b1;
        pc        = a;
        exp_code_q.push_back(c);
        exp_err_q.push_back(e);
        cyc();
        fetch_req = 1'b0;
    endtask

    task automatic do_load(input logic [AW-1:0] a, input logic [31:0] d);
        ld_valid = 1'b1;
        ld_addr  = a;
        ld_data  = d;
        cyc();
        ld_valid = 1'b0;
    endtask

    task automatic do_both(input logic [AW-1:0] la, input logic [31:0] d,
                           input logic [31:0] a, input logic [31:0] c, input logic [1:0] e);
        ld_valid = 1'b1;
        ld_addr  = la;
        ld_data  = d;
        do_fetch(a, c, e);
        ld_valid = 1'b0;
    endtask

    initial begin
        int n;
        reset     = 1'b1;
        ld_valid  = 1'b0;
        ld_addr   = '0;
        ld_data   = '0;
        fetch_req = 1'b0;
        pc        = '0;
        repeat (2) cyc();

        check_val("rst_init_done", {31'b0, init_done}, 32'd0);
        check_val("rst_ld_ready", {31'b0, ld_ready}, 32'd0);
        check_val("rst_fetch_valid", {31'b0, fetch_valid}, 32'd0);
        check_val("rst_code", instruction_code, 32'd0);
        check_val("rst_err", {30'b0, fetch_err}, 32'd0);

        // 1: clear takes DEPTH cycles; fetches held during INIT must be ignored
        reset     = 1'b0;
        fetch_req = 1'b1;
        pc        = 32'h0;
        wait_init(n);
        fetch_req = 1'b0;
        check_val("init_cycles", 32'(n), 32'(DEPTH));
        check_val("run_ld_ready", {31'b0, ld_ready}, 32'd1);
        check_val("run_no_stray_valid", {31'b0, fetch_valid}, 32'd0);
        do_fetch(32'h7C, NOP, 2'b00);

        // 2: load then back-to-back fetches
        do_load(AW'(0), 32'h0020_81B3);
        do_load(AW'(1), 32'h4020_A1B3);
        do_fetch(32'h0, 32'h0020_81B3, 2'b00);
        do_fetch(32'h4, 32'h4020_A1B3, 2'b00);

        // 3: same-word load+fetch reads old data; different-word both complete
        do_both(AW'(2), 32'h0002_02CC, 32'h8, NOP, 2'b00);
        do_fetch(32'h8, 32'h0002_02CC, 2'b00);
        do_both(AW'(3), 32'hCAFE_0093, 32'h4, 32'h4020_A1B3, 2'b00);
        do_fetch(32'hC, 32'hCAFE_0093, 2'b00);

        // 4: fault codes, each followed by a clean fetch
        do_fetch(32'h06, NOP, 2'b01);
        do_fetch(32'h00, 32'h0020_81B3, 2'b00);
        do_fetch(32'h80, NOP, 2'b10);
        do_fetch(32'h04, 32'h4020_A1B3, 2'b00);
        do_fetch(32'h81, NOP, 2'b11);
        do_fetch(32'h08, 32'h0002_02CC, 2'b00);
        do_fetch(32'h7E, NOP, 2'b01);

        // 5: single pulse, outputs hold while idle
        do_fetch(32'h04, 32'h4020_A1B3, 2'b00);
        for (int i = 0; i < 3; i++) begin
            cyc();
            check_val("idle_valid_low", {31'b0, fetch_valid}, 32'd0);
            check_val("idle_code_hold", instruction_code, 32'h4020_A1B3);
        end

        // 6a: reset partway through INIT restarts the full clear
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        repeat (10) cyc();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        wait_init(n);
        check_val("reinit_cycles_a", 32'(n), 32'(DEPTH));
        do_fetch(32'h8, NOP, 2'b00);

        // 6b: reset in RUN clears contents and drops the fetch in the reset cycle
        do_load(AW'(0), 32'h1234_5678);
        do_fetch(32'h0, 32'h1234_5678, 2'b00);
        reset     = 1'b1;
        fetch_req = 1'b1;
        pc        = 32'h0;
        cyc();
        fetch_req = 1'b0;
        check_val("reset_drops_fetch", {31'b0, fetch_valid}, 32'd0);
        check_val("reset_code_zero", instruction_code, 32'd0);
        reset = 1'b0;
        wait_init(n);
        check_val("reinit_cycles_b", 32'(n), 32'(DEPTH));
        do_fetch(32'h0, NOP, 2'b00);

        n = 0;
        while (exp_code_q.size() != 0 && n < 10) begin
            cyc();
            n++;
        end
        cyc();
        check_val("scoreboard_drained", 32'(exp_code_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
